// File: rtl/axi_rd_guard_pkg.sv
// Shared types and default widths for the AXI read transaction guard.
package axi_rd_guard_pkg;

    localparam int DefNumSlots   = 8;
    localparam int DefIdWidth    = 4;
    localparam int DefCntWidth   = 16;
    localparam int DefOlderWidth = $clog2(DefNumSlots);
    localparam int LenWidth      = 8;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_FIRST = 2'd1,
        STREAM     = 2'd2,
        TIMED_OUT  = 2'd3
    } slot_state_e;

    typedef struct packed {
        slot_state_e                state;
        logic [DefIdWidth-1:0]      id;
        logic [LenWidth-1:0]        beats_left;
        logic [DefOlderWidth-1:0]   older;
        logic [DefCntWidth-1:0]     cnt;
    } slot_t;

endpackage

// File: rtl/axi_rd_guard_slot.sv
// One tracked outstanding read: state, beat count, ID ordering rank and latency counter.
// Optional latency outputs are present when AXI_RD_GUARD_LAT_LOG_EN is defined.
module axi_rd_guard_slot
    import axi_rd_guard_pkg::*;
#(
    parameter int IdWidth    = DefIdWidth,
    parameter int CntWidth   = DefCntWidth,
    parameter int OlderWidth = DefOlderWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  alloc,
    input  logic [IdWidth-1:0]    alloc_id,
    input  logic [LenWidth-1:0]   alloc_len,
    input  logic [OlderWidth-1:0] alloc_older,
    input  logic                  beat,
    input  logic                  last,
    input  logic                  dec_older,
    input  logic [CntWidth-1:0]   budget_first,
    input  logic [CntWidth-1:0]   budget_beat,
    output slot_state_e           state,
    output logic [IdWidth-1:0]    id,
    output logic [OlderWidth-1:0] older,
    output logic                  retire,
    output logic                  timeout,
    output logic                  len_err
`ifdef AXI_RD_GUARD_LAT_LOG_EN
    ,
    output logic                  first_beat,
    output logic [CntWidth-1:0]   cnt_now
`endif
);

    logic [LenWidth-1:0] beats_left;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] cnt_inc;
    logic [CntWidth-1:0] budget;
    logic                live;

    always_comb begin
        live    = (state == WAIT_FIRST) || (state == STREAM);
        cnt_inc = (&cnt) ? cnt : cnt + CntWidth'(1);
        budget  = (state == WAIT_FIRST) ? budget_first : budget_beat;
        // Retirement happens even while tracking is disabled.
        retire  = live && beat && (last || (beats_left == '0));
        len_err = live && beat && (last ? (beats_left != '0) : (beats_left == '0));
        timeout = enable && live && !beat && (budget != '0) && (cnt_inc == budget);
    end

`ifdef AXI_RD_GUARD_LAT_LOG_EN
    assign first_beat = enable && (state == WAIT_FIRST) && beat;
    assign cnt_now    = cnt;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= FREE;
            id         <= '0;
            beats_left <= '0;
            older      <= '0;
            cnt        <= '0;
        end else if (clear) begin
            state <= FREE;
            older <= '0;
            cnt   <= '0;
        end else if (alloc) begin
            state      <= WAIT_FIRST;
            id         <= alloc_id;
            beats_left <= alloc_len;
            older      <= alloc_older;
            cnt        <= '0;
        end else begin
            if (dec_older && (older != '0)) begin
                older <= older - OlderWidth'(1);
            end
            if (retire) begin
                state <= FREE;
            end else if (enable && live) begin
                if (beat) begin
                    state      <= STREAM;
                    cnt        <= '0;
                    beats_left <= beats_left - 8'd1;
                end else begin
                    cnt <= cnt_inc;
                    if (timeout) begin
                        state <= TIMED_OUT;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi_rd_txn_guard.sv
// Passive AXI read-channel guard: tracks outstanding reads per slot and raises sticky error flags.
// Define AXI_RD_GUARD_LAT_LOG_EN to add the max_lat_o first-beat latency log.
module axi_rd_txn_guard
    import axi_rd_guard_pkg::*;
#(
    parameter int NumSlots     = DefNumSlots,
    parameter int IdWidth      = DefIdWidth,
    parameter int CntWidth     = DefCntWidth,
    parameter int SlotIdxWidth = $clog2(NumSlots)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic                    ar_valid_i,
    input  logic                    ar_ready_i,
    input  logic [IdWidth-1:0]      ar_id_i,
    input  logic [7:0]              ar_len_i,
    input  logic                    r_valid_i,
    input  logic                    r_ready_i,
    input  logic [IdWidth-1:0]      r_id_i,
    input  logic                    r_last_i,
    input  logic [CntWidth-1:0]     budget_first_i,
    input  logic [CntWidth-1:0]     budget_beat_i,
    output logic                    ar_stall_o,
    output logic [SlotIdxWidth:0]   outstanding_o,
    output logic                    timeout_o,
    output logic [IdWidth-1:0]      timeout_id_o,
    output logic                    len_err_o,
    output logic                    unexp_err_o,
    output logic                    ovf_err_o,
    output logic                    irq_o,
    output logic                    rst_req_o
`ifdef AXI_RD_GUARD_LAT_LOG_EN
    ,
    output logic [CntWidth-1:0]     max_lat_o
`endif
);

    logic ar_hs;
    logic r_beat;

    slot_state_e              st   [NumSlots];
    logic [IdWidth-1:0]       sid  [NumSlots];
    logic [SlotIdxWidth-1:0]  sold [NumSlots];
    logic [NumSlots-1:0]      alloc_vec, beat_vec, dec_vec, retire_vec, tout_vec, lerr_vec;

    logic                     full;
    logic                     head_found;
    logic                     unexp;
    logic [SlotIdxWidth-1:0]  free_idx;
    logic [SlotIdxWidth-1:0]  n_same;
    logic [SlotIdxWidth:0]    n_active;
    logic [IdWidth-1:0]       tout_id;

    assign ar_hs  = ar_valid_i && ar_ready_i;
    assign r_beat = r_valid_i && r_ready_i;

    // Head match and free-slot search look only at registered slot state.
    always_comb begin
        full       = 1'b1;
        free_idx   = '0;
        head_found = 1'b0;
        beat_vec   = '0;
        n_active   = '0;
        alloc_vec  = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (st[i] == FREE) begin
                full     = 1'b0;
                free_idx = SlotIdxWidth'(i);
            end
        end
        for (int i = 0; i < NumSlots; i++) begin
            if (st[i] != FREE) begin
                n_active = n_active + (SlotIdxWidth + 1)'(1);
            end
            if (!head_found && (st[i] != FREE) && (sid[i] == r_id_i) && (sold[i] == '0)) begin
                head_found  = 1'b1;
                beat_vec[i] = r_beat && (st[i] != TIMED_OUT);
            end
        end
        unexp = r_beat && enable_i && !(|beat_vec);
        if (ar_hs && enable_i && !full) begin
            alloc_vec[free_idx] = 1'b1;
        end
    end

    // A retiring slot is excluded from both the new slot's rank and the decrement.
    always_comb begin
        dec_vec = '0;
        n_same  = '0;
        tout_id = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if ((st[i] != FREE) && (sid[i] == r_id_i) && !retire_vec[i]) begin
                dec_vec[i] = |retire_vec;
            end
            if ((st[i] != FREE) && (sid[i] == ar_id_i) && !retire_vec[i]) begin
                n_same = n_same + SlotIdxWidth'(1);
            end
        end
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (tout_vec[i]) begin
                tout_id = sid[i];
            end
        end
    end

`ifdef AXI_RD_GUARD_LAT_LOG_EN
    logic [NumSlots-1:0] fb_vec;
    logic [CntWidth-1:0] lat [NumSlots];
    logic [CntWidth-1:0] lat_pick;
`endif

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        axi_rd_guard_slot #(
            .IdWidth    (IdWidth),
            .CntWidth   (CntWidth),
            .OlderWidth (SlotIdxWidth)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .enable       (enable_i),
            .clear        (clear_i),
            .alloc        (alloc_vec[g]),
            .alloc_id     (ar_id_i),
            .alloc_len    (ar_len_i),
            .alloc_older  (n_same),
            .beat         (beat_vec[g]),
            .last         (r_last_i),
            .dec_older    (dec_vec[g]),
            .budget_first (budget_first_i),
            .budget_beat  (budget_beat_i),
            .state        (st[g]),
            .id           (sid[g]),
            .older        (sold[g]),
            .retire       (retire_vec[g]),
            .timeout      (tout_vec[g]),
            .len_err      (lerr_vec[g])
`ifdef AXI_RD_GUARD_LAT_LOG_EN
            ,
            .first_beat   (fb_vec[g]),
            .cnt_now      (lat[g])
`endif
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_o    <= 1'b0;
            timeout_id_o <= '0;
            len_err_o    <= 1'b0;
            unexp_err_o  <= 1'b0;
            ovf_err_o    <= 1'b0;
        end else if (clear_i) begin
            timeout_o    <= 1'b0;
            timeout_id_o <= '0;
            len_err_o    <= 1'b0;
            unexp_err_o  <= 1'b0;
            ovf_err_o    <= 1'b0;
        end else begin
            if (|lerr_vec)                  len_err_o   <= 1'b1;
            if (unexp)                      unexp_err_o <= 1'b1;
            if (ar_hs && enable_i && full)  ovf_err_o   <= 1'b1;
            if (!timeout_o && (|tout_vec)) begin
                timeout_o    <= 1'b1;
                timeout_id_o <= tout_id;
            end
        end
    end

`ifdef AXI_RD_GUARD_LAT_LOG_EN
    always_comb begin
        lat_pick = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (fb_vec[i] && (lat[i] > lat_pick)) begin
                lat_pick = lat[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_lat_o <= '0;
        end else if (clear_i) begin
            max_lat_o <= '0;
        end else if ((|fb_vec) && (lat_pick > max_lat_o)) begin
            max_lat_o <= lat_pick;
        end
    end
`endif

    assign ar_stall_o    = full;
    assign outstanding_o = n_active;
    assign irq_o         = timeout_o || len_err_o || unexp_err_o || ovf_err_o;
    assign rst_req_o     = timeout_o;

endmodule

// File: tb/tb_axi_rd_txn_guard.sv
// Bench for axi_rd_txn_guard: directed scenarios plus random traffic against a transaction-level model.
module tb_axi_rd_txn_guard;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, clr, arv, arr, rv, rr, rl;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [15:0] bf, bb;
    logic        stall, tout, lerr, unexp, ovf, irq, rreq;
    logic [3:0]  outst, tid;
`ifdef AXI_RD_GUARD_LAT_LOG_EN
    logic [15:0] max_lat;
`endif

    always #5 clk = ~clk;

    axi_rd_txn_guard dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (en),
        .clear_i        (clr),
        .ar_valid_i     (arv),
        .ar_ready_i     (arr),
        .ar_id_i        (arid),
        .ar_len_i       (arlen),
        .r_valid_i      (rv),
        .r_ready_i      (rr),
        .r_id_i         (rid),
        .r_last_i       (rl),
        .budget_first_i (bf),
        .budget_beat_i  (bb),
        .ar_stall_o     (stall),
        .outstanding_o  (outst),
        .timeout_o      (tout),
        .timeout_id_o   (tid),
        .len_err_o      (lerr),
        .unexp_err_o    (unexp),
        .ovf_err_o      (ovf),
        .irq_o          (irq),
        .rst_req_o      (rreq)
`ifdef AXI_RD_GUARD_LAT_LOG_EN
        ,
        .max_lat_o      (max_lat)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: per-ID order is allocation order, deadlines are timestamps.
    typedef struct {
        bit v;
        bit to;
        int id;
        int len;
        int beats;
        int t_ev;
        int seq;
    } rec_t;

    rec_t m [NS];
    int   now = 0;
    int   seq_n = 0;
    bit   m_to, m_len, m_unexp, m_ovf;
    int   m_tid;

    function automatic int head_of(int id);
        int h = -1;
        for (int i = 0; i < NS; i++)
            if (m[i].v && m[i].id == id && (h < 0 || m[i].seq < m[h].seq)) h = i;
        return h;
    endfunction

    task automatic model_step();
        int fr, h, bud;
        now++;
        if (clr) begin
            for (int i = 0; i < NS; i++) m[i].v = 0;
            m_to = 0; m_len = 0; m_unexp = 0; m_ovf = 0; m_tid = 0;
            return;
        end
        fr = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m[i].v) fr = i;
        if (rv && rr) begin
            h = head_of(int'(rid));
            if (h < 0 || m[h].to) begin
                if (en) m_unexp = 1;
            end else begin
                if (rl != (m[h].beats == m[h].len)) m_len = 1;
                if (rl || m[h].beats == m[h].len) m[h].v = 0;
                else if (en) begin
                    m[h].beats++;
                    m[h].t_ev = now;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (m[i].v && !m[i].to) begin
                if (!en) m[i].t_ev++;
                else begin
                    bud = (m[i].beats == 0) ? int'(bf) : int'(bb);
                    if (bud != 0 && now - m[i].t_ev == bud) begin
                        m[i].to = 1;
                        if (!m_to) begin
                            m_to = 1;
                            m_tid = m[i].id;
                        end
                    end
                end
            end
        end
        if (arv && arr && en) begin
            if (fr >= 0) begin
                m[fr] = '{v: 1, to: 0, id: int'(arid), len: int'(arlen), beats: 0, t_ev: now, seq: seq_n};
                seq_n++;
            end else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        int n = 0;
        for (int i = 0; i < NS; i++) if (m[i].v) n++;
        chk("outstanding", 32'(outst), 32'(n));
        chk("ar_stall", 32'(stall), 32'(n == NS));
        chk("timeout", 32'(tout), 32'(m_to));
        chk("timeout_id", 32'(tid), 32'(m_tid));
        chk("len_err", 32'(lerr), 32'(m_len));
        chk("unexp_err", 32'(unexp), 32'(m_unexp));
        chk("ovf_err", 32'(ovf), 32'(m_ovf));
        chk("irq", 32'(irq), 32'(m_to | m_len | m_unexp | m_ovf));
        chk("rst_req", 32'(rreq), 32'(m_to));
    endtask

    task automatic step_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cyc(bit a_v, int a_id, int a_len, bit r_v, int r_id, bit r_l);
        arv = a_v; arr = 1'b1; arid = 4'(a_id); arlen = 8'(a_len);
        rv = r_v; rr = 1'b1; rid = 4'(r_id); rl = r_l;
        step_check();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        clr = 1'b0;
    endtask

    initial begin
        int h;
        en = 1'b1; clr = 1'b0; arv = 1'b0; arr = 1'b0; arid = '0; arlen = '0;
        rv = 1'b0; rr = 1'b0; rid = '0; rl = 1'b0; bf = 16'd10; bb = 16'd4;
        repeat (2) @(negedge clk);
        chk("rst_outstanding", 32'(outst), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_timeout", 32'(tout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal 4-beat burst with first beat 5 cycles after AR.
        cyc(1, 3, 3, 0, 0, 0);
        chk("t1_alloc", 32'(outst), 32'd1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 1, 3, 1);
        chk("t1_freed", 32'(outst), 32'd0);
        chk("t1_irq", 32'(irq), 32'd0);

        // First-beat timeout exactly budget cycles after the AR handshake.
        bf = 16'd6;
        cyc(1, 1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0);
        chk("t2_early", 32'(tout), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t2_timeout", 32'(tout), 32'd1);
        chk("t2_rst_req", 32'(rreq), 32'd1);
        chk("t2_tid", 32'(tid), 32'd1);
        chk("t2_irq", 32'(irq), 32'd1);
        do_clear();
        chk("t2_clear_irq", 32'(irq), 32'd0);
        chk("t2_clear_outst", 32'(outst), 32'd0);
        bf = 16'd10;

        // Same-ID ordering.
        cyc(1, 2, 0, 0, 0, 0);
        cyc(1, 2, 1, 0, 0, 0);
        chk("t3_two", 32'(outst), 32'd2);
        cyc(0, 0, 0, 1, 2, 1);
        chk("t3_first_ret", 32'(outst), 32'd1);
        cyc(0, 0, 0, 1, 2, 0);
        chk("t3_mid", 32'(outst), 32'd1);
        cyc(0, 0, 0, 1, 2, 1);
        chk("t3_done", 32'(outst), 32'd0);
        chk("t3_len_err", 32'(lerr), 32'd0);

        // Table full and overflow.
        for (int k = 0; k < NS; k++) cyc(1, k, 0, 0, 0, 0);
        chk("t4_stall", 32'(stall), 32'd1);
        cyc(1, 8, 0, 0, 0, 0);
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_outst", 32'(outst), 32'd8);
        do_clear();

        // Unexpected response.
        cyc(0, 0, 0, 1, 5, 1);
        chk("t5_unexp", 32'(unexp), 32'd1);
        chk("t5_outst", 32'(outst), 32'd0);
        do_clear();

        // Early last.
        cyc(1, 4, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 0);
        cyc(0, 0, 0, 1, 4, 1);
        chk("t6_len_err", 32'(lerr), 32'd1);
        chk("t6_freed", 32'(outst), 32'd0);
        do_clear();

        // Same-cycle AR and R for a fresh ID, then disabled allocation.
        cyc(1, 7, 0, 1, 7, 1);
        chk("t7_unexp", 32'(unexp), 32'd1);
        chk("t7_alloc", 32'(outst), 32'd1);
        cyc(0, 0, 0, 1, 7, 1);
        chk("t7_ret", 32'(outst), 32'd0);
        do_clear();
        en = 1'b0;
        cyc(1, 6, 0, 0, 0, 0);
        chk("t8_disabled", 32'(outst), 32'd0);
        en = 1'b1;
        do_clear();

        bf = 16'd12;
        bb = 16'd6;
        for (int c = 0; c < 3000; c++) begin
            en    = ($urandom_range(99) >= 3);
            clr   = ($urandom_range(199) == 0);
            arv   = ($urandom_range(9) < 4);
            arr   = ($urandom_range(9) < 7);
            arid  = 4'($urandom_range(3));
            arlen = 8'($urandom_range(3));
            rv    = ($urandom_range(9) < 6);
            rr    = ($urandom_range(9) < 8);
            rid   = 4'($urandom_range(3));
            h     = head_of(int'(rid));
            if (h >= 0) rl = (m[h].beats == m[h].len) ^ ($urandom_range(19) == 0);
            else        rl = 1'($urandom_range(1));
            step_check();
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
